// File: rtl/wb_arbiter_if.sv
// Bus bundle between the ALU/LSU result producers and the write-back arbiter.
`ifndef RF_ADDR_WIDTH
`define RF_ADDR_WIDTH 5
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

interface wb_arbiter_if #(
  parameter int unsigned LQ_DEPTH = 2
);
  logic                        alu_valid;
  logic                        alu_ready;
  logic [`RF_ADDR_WIDTH-1:0]   alu_rd;
  logic [`WORD_WIDTH-1:0]      alu_data;
  logic                        lsu_valid;
  logic                        lsu_ready;
  logic [`RF_ADDR_WIDTH-1:0]   lsu_rd;
  logic [`WORD_WIDTH-1:0]      lsu_data;
  logic                        regWrite;
  logic [`RF_ADDR_WIDTH-1:0]   writeAddr;
  logic [`WORD_WIDTH-1:0]      dataIn;
  logic [$clog2(LQ_DEPTH):0]   lq_count;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready, regWrite, writeAddr, dataIn, lq_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready, regWrite, writeAddr, dataIn, lq_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Merges ALU and queued load results onto one register-file write port, ALU first,
// with a starvation guard that forces a load drain after a run of ALU wins on a full queue.
`ifndef RF_ADDR_WIDTH
`define RF_ADDR_WIDTH 5
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module wb_arbiter #(
  parameter int unsigned LQ_DEPTH     = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          rst,
  wb_arbiter_if.slave  bus
);
  localparam int unsigned PtrW = $clog2(LQ_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] Depth     = CntW'(LQ_DEPTH);
  localparam logic [StW-1:0]  StarveMax = StW'(STARVE_LIMIT);

  typedef logic [`RF_ADDR_WIDTH-1:0] addr_t;
  typedef logic [`WORD_WIDTH-1:0]    word_t;

  addr_t           lq_rd_q   [LQ_DEPTH];
  word_t           lq_data_q [LQ_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [StW-1:0]  starve_q, starve_d;
  logic            reg_write_q;
  addr_t           write_addr_q;
  word_t           data_in_q;

  logic full, drain, alu_win, push, pop;

  assign full  = (count_q == Depth);
  assign drain = (starve_q == StarveMax);

  // Readies depend on registered state; forced high while reset is asserted.
  assign bus.alu_ready = rst | ~drain;
  assign bus.lsu_ready = rst | ~full;

  assign alu_win = bus.alu_valid & bus.alu_ready & (bus.alu_rd != '0);
  assign push    = bus.lsu_valid & bus.lsu_ready & (bus.lsu_rd != '0);
  assign pop     = ~alu_win & (count_q != '0);

  always_comb begin
    starve_d = starve_q;
    if (drain || !full) begin
      starve_d = '0;
    end else if (alu_win) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      lq_rd_q[wr_ptr_q]   <= bus.lsu_rd;
      lq_data_q[wr_ptr_q] <= bus.lsu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      reg_write_q  <= 1'b0;
      write_addr_q <= '0;
      data_in_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_q + CntW'(push) - CntW'(pop);
      starve_q    <= starve_d;
      reg_write_q <= alu_win | pop;
      // Address/data hold their last value on idle cycles.
      if (alu_win) begin
        write_addr_q <= bus.alu_rd;
        data_in_q    <= bus.alu_data;
      end else if (pop) begin
        write_addr_q <= lq_rd_q[rd_ptr_q];
        data_in_q    <= lq_data_q[rd_ptr_q];
      end
    end
  end

  assign bus.regWrite  = reg_write_q;
  assign bus.writeAddr = write_addr_q;
  assign bus.dataIn    = data_in_q;
  assign bus.lq_count  = count_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and randomized checks of wb_arbiter against a queue-based reference model.
`ifndef RF_ADDR_WIDTH
`define RF_ADDR_WIDTH 5
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module tb_wb_arbiter;
  localparam int D     = 2;
  localparam int LIMIT = 4;

  typedef struct {
    logic [`RF_ADDR_WIDTH-1:0] rd;
    logic [`WORD_WIDTH-1:0]    data;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_arbiter_if #(.LQ_DEPTH(D)) bus ();

  wb_arbiter #(
    .LQ_DEPTH     (D),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  ent_t                      q[$];
  int                        run = 0;  // consecutive ALU wins while queue full
  logic                      e_we = 1'b0;
  logic [`RF_ADDR_WIDTH-1:0] e_addr = '0;
  logic [`WORD_WIDTH-1:0]    e_data = '0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(bit r, bit av, logic [`RF_ADDR_WIDTH-1:0] ard, logic [`WORD_WIDTH-1:0] ad,
                      bit lv, logic [`RF_ADDR_WIDTH-1:0] lrd, logic [`WORD_WIDTH-1:0] ld);
    bit   e_ar, e_lr, was_full, win;
    ent_t h;
    rst           = r;
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = ad;
    bus.lsu_valid = lv;
    bus.lsu_rd    = lrd;
    bus.lsu_data  = ld;
    #1;
    e_ar = r || (run < LIMIT);
    e_lr = r || (q.size() < D);
    chk("alu_ready", {31'b0, bus.alu_ready}, {31'b0, e_ar});
    chk("lsu_ready", {31'b0, bus.lsu_ready}, {31'b0, e_lr});
    if (r) begin
      q.delete();
      run    = 0;
      e_we   = 1'b0;
      e_addr = '0;
      e_data = '0;
    end else begin
      was_full = (q.size() == D);
      win      = av && e_ar && (ard != 0);
      if (win) begin
        e_we = 1'b1; e_addr = ard; e_data = ad;
      end else if (q.size() > 0) begin
        h = q.pop_front();
        e_we = 1'b1; e_addr = h.rd; e_data = h.data;
      end else begin
        e_we = 1'b0;
      end
      if (lv && e_lr && lrd != 0) q.push_back('{lrd, ld});
      if (!e_ar || !was_full) run = 0;
      else if (win) run++;
    end
    @(posedge clk);
    #1;
    chk("regWrite", {31'b0, bus.regWrite}, {31'b0, e_we});
    chk("writeAddr", {27'b0, bus.writeAddr}, {27'b0, e_addr});
    chk("dataIn", bus.dataIn, e_data);
    chk("lq_count", {29'b0, bus.lq_count}, q.size());
    chk("addr_nonzero", {31'b0, bus.regWrite && bus.writeAddr == 0}, 32'd0);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;

    // Reset with handshakes offered: must be ignored
    step(1, 1, 4, 32'h1234, 1, 6, 32'h55);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_regWrite", {31'b0, bus.regWrite}, 32'd0);
    chk("rst_lq_count", {29'b0, bus.lq_count}, 32'd0);

    // ALU-only write
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    chk("alu_only_addr", {27'b0, bus.writeAddr}, 32'd5);
    chk("alu_only_data", bus.dataIn, 32'hDEADBEEF);
    idle();
    chk("idle_hold_data", bus.dataIn, 32'hDEADBEEF);

    // Load queued behind ALU
    step(0, 1, 3, 32'hA5A5, 1, 7, 32'h11);
    chk("behind_alu_addr", {27'b0, bus.writeAddr}, 32'd3);
    idle();
    chk("behind_load_addr", {27'b0, bus.writeAddr}, 32'd7);
    chk("behind_load_data", bus.dataIn, 32'h11);
    idle();

    // Full queue + starvation drain
    step(0, 1, 1, 32'h100, 1, 10, 32'hA0);
    step(0, 1, 1, 32'h101, 1, 11, 32'hA1);
    chk("full_count", {29'b0, bus.lq_count}, 32'd2);
    for (int i = 0; i < LIMIT; i++) step(0, 1, 1, 32'h200 + i, 1, 12, 32'hBAD);
    step(0, 1, 1, 32'h300, 0, 0, 0);  // drain cycle: alu_ready expected 0
    chk("drain_addr", {27'b0, bus.writeAddr}, 32'd10);
    chk("drain_data", bus.dataIn, 32'hA0);
    idle(); idle();

    // rd == 0 handling
    step(0, 0, 0, 0, 1, 9, 32'h99);
    step(0, 1, 0, 32'hFFFF, 0, 0, 0);
    chk("alu_rd0_load_addr", {27'b0, bus.writeAddr}, 32'd9);
    step(0, 0, 0, 0, 1, 0, 32'h77);
    chk("lsu_rd0_count", {29'b0, bus.lq_count}, 32'd0);
    chk("lsu_rd0_nowrite", {31'b0, bus.regWrite}, 32'd0);

    // Wrap-around: 6 loads with interleaved ALU traffic
    for (int i = 0; i < 6; i++) step(0, i[0], 2, 32'h40 + i, 1, 5'(12 + i), 32'hC0 + i);
    repeat (3) idle();

    // Reset mid-operation with a full queue
    step(0, 1, 1, 32'h1, 1, 20, 32'hE0);
    step(0, 1, 1, 32'h2, 1, 21, 32'hE1);
    chk("pre_rst_count", {29'b0, bus.lq_count}, 32'd2);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("post_rst_count", {29'b0, bus.lq_count}, 32'd0);
    chk("post_rst_regWrite", {31'b0, bus.regWrite}, 32'd0);
    repeat (3) idle();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 7) != 0,
           5'($urandom_range(0, 31)),
           $urandom,
           $urandom_range(0, 1) == 1,
           ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
           $urandom);
    end
    repeat (4) idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter LQ_DEPTH, default 2, meaning load-result queue entries (power of two, >=2).
REQ-002 Parameter STARVE_LIMIT, default 4, meaning consecutive ALU-priority cycles tolerated while the queue is full.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 alu_valid  input  1  ALU result present this cycle.
REQ-006 alu_ready  output  1  ALU result accepted this cycle.
REQ-007 alu_rd  input  `RF_ADDR_WIDTH  ALU destination register.
REQ-008 alu_data  input  `WORD_WIDTH  ALU result.
REQ-009 lsu_valid  input  1  load result offered.
REQ-010 lsu_ready  output  1  load result accepted on lsu_valid && lsu_ready.
REQ-011 lsu_rd  input  `RF_ADDR_WIDTH  load destination register.
REQ-012 lsu_data  input  `WORD_WIDTH  load data.
REQ-013 regWrite  output  1  register-file write enable, registered.
REQ-014 writeAddr  output  `RF_ADDR_WIDTH  register-file write address, registered.
REQ-015 dataIn  output  `WORD_WIDTH  register-file write data, registered.
REQ-016 lq_count  output  $clog2(LQ_DEPTH)+1  queued load entries.

Function
REQ-017 The block SHALL merge ALU and load results onto the single register-file write port, one write per cycle maximum.
REQ-018 Load results SHALL enter a FIFO of LQ_DEPTH entries; lsu_ready = (lq_count < LQ_DEPTH), from registered state only; no push when full even if a pop occurs that cycle.
REQ-019 A load handshake with lsu_rd == 0 SHALL be accepted (lsu_ready rules unchanged) and discarded, not enqueued.
REQ-020 alu_ready SHALL be 1 except on a drain cycle (REQ-023).
REQ-021 Arbitration per cycle: accepted ALU result with alu_rd != 0 wins the port; otherwise a non-empty FIFO pops its head onto the port.
REQ-022 An accepted ALU result with alu_rd == 0 SHALL NOT use the port; FIFO may pop that cycle.
REQ-023 Starvation counter increments each cycle the FIFO is full and an ALU write wins; on reaching STARVE_LIMIT the next cycle is a drain cycle: alu_ready = 0, FIFO head popped; counter clears on drain or whenever FIFO not full.
REQ-024 Latency: a write selected in cycle N SHALL appear as regWrite=1 with writeAddr/dataIn in cycle N+1; cycles with no selected write drive regWrite=0, writeAddr/dataIn hold last values.
REQ-025 writeAddr SHALL never be 0 while regWrite=1.
REQ-026 Simultaneous push and pop on a non-full FIFO SHALL leave lq_count unchanged and preserve FIFO order; pointers wrap modulo LQ_DEPTH.
REQ-027 Load results SHALL write in acceptance order; no result is lost or duplicated.

Reset
REQ-028 While rst=1 at a clock edge: regWrite=0, writeAddr=0, dataIn=0, lq_count=0, FIFO pointers=0, starvation counter=0.
REQ-029 During and after reset alu_ready=1, lsu_ready=1; handshakes in a reset cycle SHALL be ignored.
REQ-030 Reset mid-operation SHALL discard all queued load results and any pending write.

Verification
REQ-031 ALU-only: alu_valid=1, rd=5, data=0xDEADBEEF -> next cycle regWrite=1, writeAddr=5, dataIn=0xDEADBEEF.
REQ-032 Load queued behind ALU: cycle 0 alu rd=3 and lsu rd=7 data=0x11 both valid -> cycle 1 writes x3, cycle 2 writes x7=0x11.
REQ-033 Full queue: alu_valid held 1 (rd=1), 2 loads pushed -> lsu_ready=0 while lq_count=2; after 4 ALU-won cycles one drain cycle with alu_ready=0 writes oldest load.
REQ-034 rd=0: alu rd=0 with one queued load rd=9 -> load written next cycle; lsu rd=0 handshake -> lq_count unchanged, no write.
REQ-035 Wrap-around: 6 loads through LQ_DEPTH=2 with interleaved pops -> written in order, lq_count never >2.
REQ-036 Reset with lq_count=2 -> next cycle lq_count=0, regWrite=0, queued loads never written.
